// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle word memory behind a valid/ready request
// port, returning one response pulse per accepted load or store.
// Optional feature macro: DMEM_BYTE_ENABLE_EN (per-lane store masking).
module data_memory_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddress,
    input  logic [3:0]  reqByteEnable,
    input  logic [31:0] reqWriteData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respError
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Storage is deliberately excluded from reset; zero only at time 0.
    logic [31:0] mem_q [DEPTH] = '{default: '0};

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_error_q, resp_error_d;

    logic                  accept;
    logic                  enter_resp;
    logic                  cur_write;
    logic [31:0]           cur_addr;
    logic [3:0]            cur_be;
    logic [31:0]           cur_wdata;
    logic [31:0]           cur_high;
    logic                  cur_err;
    logic [ADDR_WIDTH-1:0] cur_idx;

    // With LATENCY==1 the RESP entry edge is the accept edge, so the live
    // request fields are used in IDLE and the latched copies otherwise.
    always_comb begin
        accept     = (state_q == IDLE) && reqValid;
        cur_write  = (state_q == IDLE) ? reqWrite      : write_q;
        cur_addr   = (state_q == IDLE) ? reqAddress    : addr_q;
        cur_be     = (state_q == IDLE) ? reqByteEnable : be_q;
        cur_wdata  = (state_q == IDLE) ? reqWriteData  : wdata_q;
        cur_high   = cur_addr >> (ADDR_WIDTH + 2);
        cur_err    = (cur_addr[1:0] != 2'b00) || (cur_high != '0);
        cur_idx    = cur_addr[ADDR_WIDTH+1:2];
        enter_resp = (accept && (LATENCY == 1)) ||
                     ((state_q == WAIT) && (count_q == 4'd1));
    end

    // Next-state, request latch and response computation.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        write_d      = write_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        resp_data_d  = '0;
        resp_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = reqWrite;
                    addr_d  = reqAddress;
                    be_d    = reqByteEnable;
                    wdata_d = reqWriteData;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        count_d = '0;
                    end else begin
                        state_d = WAIT;
                        count_d = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = RESP;
                    count_d = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
        if (enter_resp) begin
            resp_error_d = cur_err;
            if (!cur_write && !cur_err) begin
                resp_data_d = mem_q[cur_idx];
            end
        end
        ready_d      = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
        end
    end

`ifdef DMEM_BYTE_ENABLE_EN
    // Store commit on the RESP entry edge, one byte lane per mask bit.
    always_ff @(posedge clock) begin
        if (reset && enter_resp && cur_write && !cur_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end
`else
    logic unused_be;
    assign unused_be = ^cur_be;

    // Store commit on the RESP entry edge, always the full word.
    always_ff @(posedge clock) begin
        if (reset && enter_resp && cur_write && !cur_err) begin
            mem_q[cur_idx] <= cur_wdata;
        end
    end
`endif

    assign reqReady  = ready_q;
    assign respValid = resp_valid_q;
    assign respData  = resp_data_q;
    assign respError = resp_error_q;

endmodule
